// File: rtl/dhazard_if.sv
// Shared types and the decode-hazard bus between pipeline and hazard unit.
// dhazard_pkg holds operand-select and hazard-state encodings.
package dhazard_pkg;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    FWD_NONE    = 2'd0,
    FWD_RESULT  = 2'd1,
    FWD_PCPLUS4 = 2'd2,
    FWD_WD      = 2'd3
  } forward_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_FREEZE = 2'd2,
    ST_FLUSH  = 2'd3
  } hz_state_t;
endpackage

interface dhazard_if;
  import dhazard_pkg::*;

  logic             d_valid;
  logic [REG_W-1:0] d_rs1;
  logic [REG_W-1:0] d_rs2;
  logic             d_use1;
  logic             d_use2;
  logic             e_valid;
  logic             e_regwrite;
  logic             e_memread;
  logic [REG_W-1:0] e_rd;
  logic             m_valid;
  logic             m_regwrite;
  logic             m_memread;
  logic             m_link;
  logic [REG_W-1:0] m_rd;
  logic             w_valid;
  logic             w_regwrite;
  logic [REG_W-1:0] w_rd;
  logic             dmem_busy;
  logic             e_redirect;

  forward_t         fwd1;
  forward_t         fwd2;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  hz_state_t        hz_state;
  logic             hz_err;
  logic [CNT_W-1:0] cnt_bubble;
  logic [CNT_W-1:0] cnt_freeze;
  logic [CNT_W-1:0] cnt_flush;

  modport master (
    output d_valid, d_rs1, d_rs2, d_use1, d_use2,
    output e_valid, e_regwrite, e_memread, e_rd,
    output m_valid, m_regwrite, m_memread, m_link, m_rd,
    output w_valid, w_regwrite, w_rd,
    output dmem_busy, e_redirect,
    input  fwd1, fwd2, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
    input  hz_state, hz_err, cnt_bubble, cnt_freeze, cnt_flush
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_use1, d_use2,
    input  e_valid, e_regwrite, e_memread, e_rd,
    input  m_valid, m_regwrite, m_memread, m_link, m_rd,
    input  w_valid, w_regwrite, w_rd,
    input  dmem_busy, e_redirect,
    output fwd1, fwd2, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
    output hz_state, hz_err, cnt_bubble, cnt_freeze, cnt_flush
  );
endinterface

// File: rtl/dhazard.sv
// Decode-stage hazard unit: operand forwarding select, stall/flush control, stall watchdog.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module dhazard
  import dhazard_pkg::*;
(
  input  logic     clk,
  input  logic     resetn,
  dhazard_if.slave hz
);

  localparam int unsigned BUB_W   = 2;
  localparam int unsigned BUB_MAX = 2;

  function automatic logic src_match(input logic             src_use,
                                     input logic [REG_W-1:0] rs,
                                     input logic             stg_valid,
                                     input logic             stg_wr,
                                     input logic [REG_W-1:0] rd);
    return src_use & (rs != '0) & stg_valid & stg_wr & (rd == rs);
  endfunction

  // M beats W; a load in M has no usable result yet so it falls through.
  function automatic forward_t fwd_sel(input logic m_hit, input logic w_hit,
                                       input logic link, input logic memread);
    forward_t sel;
    sel = FWD_NONE;
    if (m_hit && link)          sel = FWD_PCPLUS4;
    else if (m_hit && !memread) sel = FWD_RESULT;
    else if (w_hit)             sel = FWD_WD;
    return sel;
  endfunction

  logic e_hit1, e_hit2, m_hit1, m_hit2, w_hit1, w_hit2;
  logic e_hit, m_load_hit, dep_hazard;

  assign e_hit1 = src_match(hz.d_use1, hz.d_rs1, hz.e_valid, hz.e_regwrite, hz.e_rd);
  assign e_hit2 = src_match(hz.d_use2, hz.d_rs2, hz.e_valid, hz.e_regwrite, hz.e_rd);
  assign m_hit1 = src_match(hz.d_use1, hz.d_rs1, hz.m_valid, hz.m_regwrite, hz.m_rd);
  assign m_hit2 = src_match(hz.d_use2, hz.d_rs2, hz.m_valid, hz.m_regwrite, hz.m_rd);
  assign w_hit1 = src_match(hz.d_use1, hz.d_rs1, hz.w_valid, hz.w_regwrite, hz.w_rd);
  assign w_hit2 = src_match(hz.d_use2, hz.d_rs2, hz.w_valid, hz.w_regwrite, hz.w_rd);

  assign hz.fwd1 = fwd_sel(m_hit1, w_hit1, hz.m_link, hz.m_memread);
  assign hz.fwd2 = fwd_sel(m_hit2, w_hit2, hz.m_link, hz.m_memread);

  // Nothing in E is forwardable to decode, whether load or ALU producer.
  assign e_hit      = e_hit1 | e_hit2;
  assign m_load_hit = (m_hit1 | m_hit2) & hz.m_memread;
  assign dep_hazard = hz.d_valid &
                      ((e_hit & hz.e_memread) | (e_hit & ~hz.e_memread) | m_load_hit);

  hz_state_t state_q, state_d;
  logic      stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;

  always_ff @(posedge clk or negedge resetn) begin : state_reg
    if (!resetn) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = ST_RUN;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (hz.dmem_busy) begin
      state_d = ST_FREEZE;
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (hz.e_redirect) begin
      state_d = ST_FLUSH;
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (dep_hazard) begin
      state_d = ST_BUBBLE;
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign hz.stall_f  = stall_f;
  assign hz.stall_d  = stall_d;
  assign hz.stall_e  = stall_e;
  assign hz.stall_m  = stall_m;
  assign hz.flush_d  = flush_d;
  assign hz.flush_e  = flush_e;
  assign hz.hz_state = state_q;

  logic [BUB_W-1:0] bubble_cnt_q;
  logic             err_q;

  // A dependency can stall at most twice; a third back-to-back bubble is a protocol error.
  always_ff @(posedge clk or negedge resetn) begin : bubble_watch
    if (!resetn) begin
      bubble_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_d)
        ST_BUBBLE: begin
          if (bubble_cnt_q == BUB_W'(BUB_MAX)) err_q <= 1'b1;
          if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + BUB_W'(1);
        end
        ST_FREEZE: bubble_cnt_q <= bubble_cnt_q;
        default:   bubble_cnt_q <= '0;
      endcase
    end
  end

  assign hz.hz_err = err_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] cnt_bubble_q, cnt_freeze_q, cnt_flush_q;

  always_ff @(posedge clk or negedge resetn) begin : perf_cnt
    if (!resetn) begin
      cnt_bubble_q <= '0;
      cnt_freeze_q <= '0;
      cnt_flush_q  <= '0;
    end else begin
      if (state_d == ST_BUBBLE && cnt_bubble_q != '1) cnt_bubble_q <= cnt_bubble_q + CNT_W'(1);
      if (state_d == ST_FREEZE && cnt_freeze_q != '1) cnt_freeze_q <= cnt_freeze_q + CNT_W'(1);
      if (state_d == ST_FLUSH  && cnt_flush_q  != '1) cnt_flush_q  <= cnt_flush_q  + CNT_W'(1);
    end
  end

  assign hz.cnt_bubble = cnt_bubble_q;
  assign hz.cnt_freeze = cnt_freeze_q;
  assign hz.cnt_flush  = cnt_flush_q;
`else
  assign hz.cnt_bubble = '0;
  assign hz.cnt_freeze = '0;
  assign hz.cnt_flush  = '0;
`endif

endmodule

// File: tb/tb_dhazard.sv
// Bench for dhazard: rule-level reference model checked every cycle plus directed scenarios.
module tb_dhazard;

  typedef struct packed {
    logic       d_valid;
    logic [4:0] d_rs1;
    logic [4:0] d_rs2;
    logic       d_use1;
    logic       d_use2;
    logic       e_valid;
    logic       e_regwrite;
    logic       e_memread;
    logic [4:0] e_rd;
    logic       m_valid;
    logic       m_regwrite;
    logic       m_memread;
    logic       m_link;
    logic [4:0] m_rd;
    logic       w_valid;
    logic       w_regwrite;
    logic [4:0] w_rd;
    logic       dmem_busy;
    logic       e_redirect;
  } vec_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  dhazard_if hz ();

  dhazard dut (
    .clk    (clk),
    .resetn (resetn),
    .hz     (hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    hz.d_valid    = v.d_valid;
    hz.d_rs1      = v.d_rs1;
    hz.d_rs2      = v.d_rs2;
    hz.d_use1     = v.d_use1;
    hz.d_use2     = v.d_use2;
    hz.e_valid    = v.e_valid;
    hz.e_regwrite = v.e_regwrite;
    hz.e_memread  = v.e_memread;
    hz.e_rd       = v.e_rd;
    hz.m_valid    = v.m_valid;
    hz.m_regwrite = v.m_regwrite;
    hz.m_memread  = v.m_memread;
    hz.m_link     = v.m_link;
    hz.m_rd       = v.m_rd;
    hz.w_valid    = v.w_valid;
    hz.w_regwrite = v.w_regwrite;
    hz.w_rd       = v.w_rd;
    hz.dmem_busy  = v.dmem_busy;
    hz.e_redirect = v.e_redirect;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (actions: 0 run, 1 bubble, 2 freeze, 3 flush)
  function automatic bit hits(input logic u, input logic [4:0] rs, input logic vld,
                              input logic wr, input logic [4:0] rd);
    return (u === 1'b1) && (rs != 0) && (vld === 1'b1) && (wr === 1'b1) && (rd == rs);
  endfunction

  function automatic int exp_fwd(input logic u, input logic [4:0] rs);
    bit in_m, in_w;
    in_m = hits(u, rs, hz.m_valid, hz.m_regwrite, hz.m_rd);
    in_w = hits(u, rs, hz.w_valid, hz.w_regwrite, hz.w_rd);
    if (in_m && hz.m_link)     return 2;
    if (in_m && !hz.m_memread) return 1;
    if (in_w)                  return 3;
    return 0;
  endfunction

  function automatic int exp_action();
    bit h;
    h = 0;
    if (hz.d_valid) begin
      if (hits(hz.d_use1, hz.d_rs1, hz.e_valid, hz.e_regwrite, hz.e_rd)) h = 1;
      if (hits(hz.d_use2, hz.d_rs2, hz.e_valid, hz.e_regwrite, hz.e_rd)) h = 1;
      if (hz.m_memread && hits(hz.d_use1, hz.d_rs1, hz.m_valid, hz.m_regwrite, hz.m_rd)) h = 1;
      if (hz.m_memread && hits(hz.d_use2, hz.d_rs2, hz.m_valid, hz.m_regwrite, hz.m_rd)) h = 1;
    end
    if (hz.dmem_busy)  return 2;
    if (hz.e_redirect) return 3;
    if (h)             return 1;
    return 0;
  endfunction

  int     exp_state = 0;
  int     bub_run   = 0;
  bit     exp_err   = 0;
  longint exp_cb    = 0;
  longint exp_cf    = 0;
  longint exp_cl    = 0;
  localparam longint CMAX = 64'hFFFF_FFFF;

  always @(posedge clk or negedge resetn) begin
    int a;
    if (!resetn) begin
      exp_state = 0;
      bub_run   = 0;
      exp_err   = 0;
      exp_cb    = 0;
      exp_cf    = 0;
      exp_cl    = 0;
    end else begin
      a = exp_action();
      exp_state = a;
      if (a == 1)      bub_run++;
      else if (a != 2) bub_run = 0;
      if (bub_run >= 3) exp_err = 1;
`ifdef HAZARD_PERF_EN
      if (a == 1 && exp_cb < CMAX) exp_cb++;
      if (a == 2 && exp_cf < CMAX) exp_cf++;
      if (a == 3 && exp_cl < CMAX) exp_cl++;
`endif
    end
  end

  // Every cycle, away from the active edge, compare all outputs with the model.
  always @(negedge clk) begin
    int a;
    a = exp_action();
    chk("fwd1",       longint'(hz.fwd1),     exp_fwd(hz.d_use1, hz.d_rs1));
    chk("fwd2",       longint'(hz.fwd2),     exp_fwd(hz.d_use2, hz.d_rs2));
    chk("stall_f",    longint'(hz.stall_f),  (a == 1 || a == 2) ? 1 : 0);
    chk("stall_d",    longint'(hz.stall_d),  (a == 1 || a == 2) ? 1 : 0);
    chk("stall_e",    longint'(hz.stall_e),  (a == 2) ? 1 : 0);
    chk("stall_m",    longint'(hz.stall_m),  (a == 2) ? 1 : 0);
    chk("flush_d",    longint'(hz.flush_d),  (a == 3) ? 1 : 0);
    chk("flush_e",    longint'(hz.flush_e),  (a == 1 || a == 3) ? 1 : 0);
    chk("hz_state",   longint'(hz.hz_state), exp_state);
    chk("hz_err",     longint'(hz.hz_err),   exp_err);
    chk("cnt_bubble", longint'(hz.cnt_bubble), exp_cb);
    chk("cnt_freeze", longint'(hz.cnt_freeze), exp_cf);
    chk("cnt_flush",  longint'(hz.cnt_flush),  exp_cl);
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios with hand-computed literals
  initial begin
    vec_t v;
    vec_t haz;
    apply('0);
    #1 resetn = 1'b0;
    repeat (2) tick();
    chk("rst_state", longint'(hz.hz_state), 0);
    chk("rst_err",   longint'(hz.hz_err), 0);
    chk("rst_cnt",   longint'(hz.cnt_freeze), 0);
    resetn = 1'b1;
    tick();

    // ALU producer x5 in M forwards Result
    v = '0; v.d_valid = 1; v.d_rs1 = 5; v.d_use1 = 1;
    v.m_valid = 1; v.m_regwrite = 1; v.m_rd = 5;
    apply(v); #1;
    chk("alu_m_fwd1",  longint'(hz.fwd1), 1);
    chk("alu_m_stall", longint'(hz.stall_f), 0);
    tick();

    // jal x1 in M beats W for the same register
    v = '0; v.d_valid = 1; v.d_rs2 = 1; v.d_use2 = 1;
    v.m_valid = 1; v.m_regwrite = 1; v.m_link = 1; v.m_rd = 1;
    v.w_valid = 1; v.w_regwrite = 1; v.w_rd = 1;
    apply(v); #1;
    chk("jal_fwd2",  longint'(hz.fwd2), 2);
    chk("jal_stall", longint'(hz.stall_d), 0);
    tick();

    // load-use on x7: two bubbles, then forward from W
    v = '0; v.d_valid = 1; v.d_rs1 = 7; v.d_use1 = 1;
    v.e_valid = 1; v.e_regwrite = 1; v.e_memread = 1; v.e_rd = 7;
    apply(v); #1;
    chk("ld_c1_stall_f", longint'(hz.stall_f), 1);
    chk("ld_c1_stall_d", longint'(hz.stall_d), 1);
    chk("ld_c1_flush_e", longint'(hz.flush_e), 1);
    chk("ld_c1_stall_e", longint'(hz.stall_e), 0);
    tick();
    chk("ld_c1_state", longint'(hz.hz_state), 1);
    v = '0; v.d_valid = 1; v.d_rs1 = 7; v.d_use1 = 1;
    v.m_valid = 1; v.m_regwrite = 1; v.m_memread = 1; v.m_rd = 7;
    apply(v); #1;
    chk("ld_c2_stall_f", longint'(hz.stall_f), 1);
    tick();
    chk("ld_c2_state", longint'(hz.hz_state), 1);
    v = '0; v.d_valid = 1; v.d_rs1 = 7; v.d_use1 = 1;
    v.w_valid = 1; v.w_regwrite = 1; v.w_rd = 7;
    apply(v); #1;
    chk("ld_c3_fwd1",  longint'(hz.fwd1), 3);
    chk("ld_c3_stall", longint'(hz.stall_f), 0);
    tick();
    chk("ld_c3_state", longint'(hz.hz_state), 0);
    chk("ld_c3_err",   longint'(hz.hz_err), 0);

    // x0 never matches
    v = '0; v.d_valid = 1; v.d_rs1 = 0; v.d_use1 = 1;
    v.e_valid = 1; v.e_regwrite = 1; v.e_rd = 0;
    apply(v); #1;
    chk("x0_fwd1",  longint'(hz.fwd1), 0);
    chk("x0_stall", longint'(hz.stall_f), 0);
    tick();

    // redirect overrides a dependency hazard
    haz = '0; haz.d_valid = 1; haz.d_rs2 = 3; haz.d_use2 = 1;
    haz.e_valid = 1; haz.e_regwrite = 1; haz.e_rd = 3;
    v = haz; v.e_redirect = 1;
    apply(v); #1;
    chk("redir_flush_d", longint'(hz.flush_d), 1);
    chk("redir_stall_f", longint'(hz.stall_f), 0);
    tick();
    chk("redir_state", longint'(hz.hz_state), 3);

    // busy + redirect + hazard for 3 cycles: freeze wins
    v = haz; v.e_redirect = 1; v.dmem_busy = 1;
    apply(v);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_stall_m", longint'(hz.stall_m), 1);
      chk("frz_flush_d", longint'(hz.flush_d), 0);
      tick();
    end
    chk("frz_state", longint'(hz.hz_state), 2);
`ifdef HAZARD_PERF_EN
    chk("frz_cnt", longint'(hz.cnt_freeze), 3);
`else
    chk("frz_cnt", longint'(hz.cnt_freeze), 0);
`endif

    // three back-to-back bubbles raise the sticky error
    apply(haz);
    tick();
    tick();
    chk("err_after2", longint'(hz.hz_err), 0);
    tick();
    chk("err_after3", longint'(hz.hz_err), 1);
    apply('0);
    tick();
    tick();
    chk("err_sticky", longint'(hz.hz_err), 1);
`ifdef HAZARD_PERF_EN
    chk("bub_cnt",   longint'(hz.cnt_bubble), 5);
    chk("flush_cnt", longint'(hz.cnt_flush), 1);
`else
    chk("bub_cnt",   longint'(hz.cnt_bubble), 0);
    chk("flush_cnt", longint'(hz.cnt_flush), 0);
`endif
    #1 resetn = 1'b0;
    #1;
    chk("async_err",   longint'(hz.hz_err), 0);
    chk("async_state", longint'(hz.hz_state), 0);
    #1 resetn = 1'b1;
    tick();
    chk("post_rst_err", longint'(hz.hz_err), 0);

    // reset during freeze returns to RUN after release
    v = '0; v.dmem_busy = 1;
    apply(v);
    tick();
    chk("pre_rst_frz", longint'(hz.hz_state), 2);
    #1 resetn = 1'b0;
    apply('0);
    tick();
    resetn = 1'b1;
    tick();
    chk("frz_rst_run", longint'(hz.hz_state), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
